// File: rtl/cdr_phase_picker_pkg.sv
// cdr_pkg: shared types, constants and helpers for the oversampling CDR phase picker.
//   phase_t     - sample phase index (0..3) within a 4x oversampled word
//   NUM_PHASES  - number of selectable sample phases
//   OVERSAMPLE  - samples per input word
//   phase_step  - one-step phase move towards a target phase
package cdr_pkg;

    typedef logic [1:0] phase_t;

    localparam int NUM_PHASES = 4;
    localparam int OVERSAMPLE = 4;

    // Moves p a single step towards t. A distance of 2 (target directly
    // opposite) is resolved by stepping forward.
    function automatic phase_t phase_step(input phase_t p, input phase_t t);
        phase_t d;
        phase_t r;
        d = t - p;
        case (d)
            2'd0:    r = p;
            2'd3:    r = p - 2'd1;
            default: r = p + 2'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cdr_phase_picker_decide.sv
// cdr_phase_decide: combinational phase decision for one window.
// Ports:
//   totals     in  per-phase edge totals for the window, including this cycle
//   phase      in  currently selected sample phase
//   phase_next out phase to use from the next valid cycle
//   wrap_up    out phase moves 3->0 (one sample would be duplicated)
//   wrap_dn    out phase moves 0->3 (one sample would be skipped)
module cdr_phase_decide
    import cdr_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic [NUM_PHASES-1:0][CNT_W-1:0] totals,
    input  phase_t                           phase,
    output phase_t                           phase_next,
    output logic                             wrap_up,
    output logic                             wrap_dn
);

    logic [CNT_W-1:0] best_cnt;
    phase_t           best_idx;

    always_comb begin
        best_cnt = totals[0];
        best_idx = '0;
        // Strict compare keeps the lowest index on ties.
        for (int k = 1; k < NUM_PHASES; k++) begin
            if (totals[k] > best_cnt) begin
                best_cnt = totals[k];
                best_idx = phase_t'(k);
            end
        end

        // Sample half a UI away from the dominant edge position.
        if (best_cnt == '0) begin
            phase_next = phase;
        end else begin
            phase_next = phase_step(phase, best_idx + 2'd2);
        end

        wrap_up = (phase == 2'd3) && (phase_next == 2'd0);
        wrap_dn = (phase == 2'd0) && (phase_next == 2'd3);
    end

endmodule

// File: rtl/cdr_phase_picker.sv
// cdr_phase_picker: back end of the 4x-oversampling CDR. Counts transitions
// per sample phase over WINDOW valid words, steers the sampling phase away
// from the edges, and emits 0, 1 or 2 recovered bits per cycle.
// Ports:
//   clk       in  word clock
//   rst_n     in  asynchronous active-low reset
//   in_valid  in  in_data valid this cycle
//   in_data   in  oversampled word, bit 0 earliest
//   out_valid out recovered bits present (registered, latency 1)
//   out_data  out recovered bits, bit 0 earlier; bit 1 only when out_cnt=2
//   out_cnt   out number of valid bits in out_data
//   out_phase out currently selected sample phase
module cdr_phase_picker
    import cdr_pkg::*;
#(
    parameter int WINDOW     = 16,
    parameter int INIT_PHASE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [OVERSAMPLE-1:0] in_data,
    output logic                  out_valid,
    output logic [1:0]            out_data,
    output logic [1:0]            out_cnt,
    output logic [1:0]            out_phase
);

    localparam int               CNT_W    = $clog2(WINDOW + 1);
    localparam int               WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam phase_t           INIT_P   = phase_t'(INIT_PHASE);

    logic                            prev_q,      prev_d;
    logic [NUM_PHASES-1:0][CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [WIN_W-1:0]                win_cnt_q,   win_cnt_d;
    phase_t                          phase_q,     phase_d;
    logic                            out_valid_q, out_valid_d;
    logic [1:0]                      out_data_q,  out_data_d;
    logic [1:0]                      out_cnt_q,   out_cnt_d;

    logic [NUM_PHASES-1:0]            edges;
    logic [NUM_PHASES-1:0][CNT_W-1:0] totals;
    logic                             dec_cycle;
    phase_t                           phase_next;
    logic                             wrap_up;
    logic                             wrap_dn;

    // Edge detection and running totals
    always_comb begin
        edges[0] = in_data[0] ^ prev_q;
        for (int k = 1; k < NUM_PHASES; k++) begin
            edges[k] = in_data[k] ^ in_data[k-1];
        end
        for (int k = 0; k < NUM_PHASES; k++) begin
            totals[k] = edge_cnt_q[k] + CNT_W'(edges[k]);
        end
        dec_cycle = in_valid && (win_cnt_q == WIN_LAST);
    end

    cdr_phase_decide #(
        .CNT_W (CNT_W)
    ) u_decide (
        .totals     (totals),
        .phase      (phase_q),
        .phase_next (phase_next),
        .wrap_up    (wrap_up),
        .wrap_dn    (wrap_dn)
    );

    // Next state and emission
    always_comb begin
        prev_d      = prev_q;
        edge_cnt_d  = edge_cnt_q;
        win_cnt_d   = win_cnt_q;
        phase_d     = phase_q;
        out_valid_d = 1'b0;
        out_cnt_d   = 2'd0;
        out_data_d  = out_data_q;

        if (in_valid) begin
            prev_d = in_data[OVERSAMPLE-1];

            if (dec_cycle) begin
                edge_cnt_d = '0;
                win_cnt_d  = '0;
                phase_d    = phase_next;
            end else begin
                edge_cnt_d = totals;
                win_cnt_d  = win_cnt_q + 1'b1;
            end

            // A 3->0 move would resample the same bit, so drop it; a 0->3
            // move would skip one, so emit both edge samples of this word.
            if (dec_cycle && wrap_up) begin
                out_valid_d = 1'b0;
                out_cnt_d   = 2'd0;
            end else if (dec_cycle && wrap_dn) begin
                out_valid_d = 1'b1;
                out_cnt_d   = 2'd2;
                out_data_d  = {in_data[3], in_data[0]};
            end else begin
                out_valid_d = 1'b1;
                out_cnt_d   = 2'd1;
                out_data_d  = {1'b0, in_data[phase_q]};
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= 1'b0;
            edge_cnt_q  <= '0;
            win_cnt_q   <= '0;
            phase_q     <= INIT_P;
            out_valid_q <= 1'b0;
            out_data_q  <= 2'd0;
            out_cnt_q   <= 2'd0;
        end else begin
            prev_q      <= prev_d;
            edge_cnt_q  <= edge_cnt_d;
            win_cnt_q   <= win_cnt_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_phase = phase_q;

endmodule
